// File: rtl/instruction_loader_pkg.sv
// Shared widths, halt opcode and FSM state encoding for the debug instruction loader.
package instruction_loader_pkg;

   localparam int SIZE_REGISTER_INST     = 32;
   localparam int SIZE_BYTE              = 8;
   localparam int SIZE_MEMORY            = 10;
   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   localparam logic [SIZE_REGISTER_INST-1:0] HALT_INST = 32'hFFFF_FFFF;

   // Program memory capacity, expressed in the width of the word counter.
   localparam logic [SIZE_MEMORY:0] MEM_WORDS = {1'b1, {SIZE_MEMORY{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } loader_state_e;

endpackage

// File: rtl/instruction_byte_packer.sv
// Big-endian byte-to-word packer: first byte lands in the top byte of the word.
module instruction_byte_packer
   import instruction_loader_pkg::*;
(
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_strobe,
   input  logic [SIZE_BYTE-1:0]          i_byte,
   input  logic                          i_clear,
   output logic [SIZE_REGISTER_INST-1:0] o_word,
   output logic                          o_word_valid
);

   localparam int PARTIAL_W = SIZE_REGISTER_INST - SIZE_BYTE;

   logic [PARTIAL_W-1:0] partial;
   logic [1:0]           index;

   // The fourth byte completes the word straight from the input, so the
   // parent can register the full word on the same edge.
   assign o_word       = {partial, i_byte};
   assign o_word_valid = i_strobe && (index == 2'd3);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         partial <= '0;
         index   <= '0;
      end else if (i_clear) begin
         partial <= '0;
         index   <= '0;
      end else if (i_strobe) begin
         index <= index + 2'd1;
         if (index == 2'd3)
            partial <= '0;
         else
            partial <= {partial[PARTIAL_W-SIZE_BYTE-1:0], i_byte};
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// UART-to-program-memory debug loader FSM; LOADER_TIMEOUT_EN adds an inter-byte
// timeout that discards stale partial words.
module instruction_loader
   import instruction_loader_pkg::*;
`ifdef LOADER_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
`endif
(
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_start,
   input  logic [SIZE_BYTE-1:0]          i_rx_data,
   input  logic                          i_rx_done,
   output logic [SIZE_REGISTER_INST-1:0] o_instruction_debug,
   output logic                          o_flag_instruction_debug,
   output logic [SIZE_MEMORY:0]          o_inst_count,
   output logic                          o_busy,
   output logic                          o_load_done,
   output logic                          o_error
);

   localparam logic [SIZE_MEMORY:0] COUNT_ONE = 1;

   loader_state_e                 state, state_next;
   logic                          byte_strobe;
   logic                          word_valid;
   logic                          clear_partial;
   logic [SIZE_REGISTER_INST-1:0] word;
   logic [SIZE_MEMORY:0]          count_inc;

   assign byte_strobe = i_rx_done && (state == ST_RECV);
   assign count_inc   = (o_inst_count == MEM_WORDS) ? o_inst_count : o_inst_count + COUNT_ONE;

   instruction_byte_packer u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_strobe     (byte_strobe),
      .i_byte       (i_rx_data),
      .i_clear      (clear_partial),
      .o_word       (word),
      .o_word_valid (word_valid)
   );

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (i_start) state_next = ST_RECV;
         ST_RECV: begin
            if (word_valid) begin
               if (word == HALT_INST)
                  state_next = ST_DONE;
               else if (count_inc == MEM_WORDS)
                  state_next = ST_ERROR;
            end
         end
         default: state_next = state;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state                    <= ST_IDLE;
         o_instruction_debug      <= '0;
         o_flag_instruction_debug <= 1'b0;
         o_inst_count             <= '0;
      end else begin
         state                    <= state_next;
         o_flag_instruction_debug <= word_valid;
         if (word_valid) begin
            o_instruction_debug <= word;
            o_inst_count        <= count_inc;
         end
      end
   end

   assign o_busy      = (state == ST_RECV);
   assign o_load_done = (state == ST_DONE);
   assign o_error     = (state == ST_ERROR);

`ifdef LOADER_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TIMER_W-1:0] timer;
   logic               pending;

   // pending mirrors "byte index != 0"; strobes only occur in RECV, so the
   // timer never runs in the other states.
   assign clear_partial = pending && !byte_strobe && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         timer   <= '0;
         pending <= 1'b0;
      end else if (byte_strobe) begin
         timer   <= '0;
         pending <= !word_valid;
      end else if (clear_partial) begin
         timer   <= '0;
         pending <= 1'b0;
      end else if (pending) begin
         timer <= timer + TIMER_W'(1);
      end
   end
`else
   assign clear_partial = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed steps plus random word fill against a byte-queue model.
module tb_instruction_loader;

   localparam int          WORD_LIMIT = 1024;
   localparam logic [31:0] HALT       = 32'hFFFF_FFFF;
`ifdef LOADER_TIMEOUT_EN
   localparam int          TIMEOUT    = 16;
`endif

   logic        i_clk     = 1'b0;
   logic        i_reset   = 1'b0;
   logic        i_start   = 1'b0;
   logic        i_rx_done = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic [31:0] o_instruction_debug;
   logic        o_flag_instruction_debug;
   logic [10:0] o_inst_count;
   logic        o_busy;
   logic        o_load_done;
   logic        o_error;

`ifdef LOADER_TIMEOUT_EN
   instruction_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
`else
   instruction_loader dut (
`endif
      .i_clk                    (i_clk),
      .i_reset                  (i_reset),
      .i_start                  (i_start),
      .i_rx_data                (i_rx_data),
      .i_rx_done                (i_rx_done),
      .o_instruction_debug      (o_instruction_debug),
      .o_flag_instruction_debug (o_flag_instruction_debug),
      .o_inst_count             (o_inst_count),
      .o_busy                   (o_busy),
      .o_load_done              (o_load_done),
      .o_error                  (o_error)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Every observed write strobe, with the cycle it was seen in.
   logic [31:0] got_words[$];
   int          got_cyc[$];
   always @(negedge i_clk) begin
      if (o_flag_instruction_debug === 1'b1) begin
         got_words.push_back(o_instruction_debug);
         got_cyc.push_back(cyc);
      end
   end

   // Reference model: loader session described as a byte queue and a word list.
   typedef enum {M_IDLE, M_RECV, M_DONE, M_ERROR} mstate_e;
   mstate_e     m_state;
   logic [7:0]  m_buf[$];
   int          m_count;
   logic [31:0] m_last;
   int          m_idle;
   logic [31:0] exp_words[$];
   int          exp_cyc[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge i_clk);
      #1;
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_buf.delete();
      m_count = 0;
      m_last  = '0;
      m_idle  = 0;
      exp_words.delete();
      exp_cyc.delete();
      got_words.delete();
      got_cyc.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [31:0] w;
      if (m_state != M_RECV) return;
      m_idle = 0;
      m_buf.push_back(b);
      if (m_buf.size() == 4) begin
         w = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
         m_buf.delete();
         m_last = w;
         exp_words.push_back(w);
         exp_cyc.push_back(cyc + 1);
         if (m_count < WORD_LIMIT) m_count++;
         if (w == HALT)
            m_state = M_DONE;
         else if (m_count == WORD_LIMIT)
            m_state = M_ERROR;
      end
   endtask

   task automatic model_quiet_edge();
`ifdef LOADER_TIMEOUT_EN
      if (m_state == M_RECV && m_buf.size() != 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_buf.delete();
            m_idle = 0;
         end
      end
`endif
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      model_byte(b);
      tick();
      i_rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         model_quiet_edge();
         tick();
      end
   endtask

   task automatic start();
      i_start = 1'b1;
      if (m_state == M_IDLE) m_state = M_RECV;
      else model_quiet_edge();
      tick();
      i_start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31-8*i -: 8]);
         if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic check_outputs(input string tag);
      int n;
      check({tag, ".busy"},  o_busy,              m_state == M_RECV);
      check({tag, ".done"},  o_load_done,         m_state == M_DONE);
      check({tag, ".error"}, o_error,             m_state == M_ERROR);
      check({tag, ".count"}, o_inst_count,        m_count);
      check({tag, ".instr"}, o_instruction_debug, m_last);
      check({tag, ".nstrobe"}, got_words.size(), exp_words.size());
      n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
      for (int i = 0; i < n; i++) begin
         check({tag, ".strobe_word"}, got_words[i], exp_words[i]);
         check({tag, ".strobe_cycle"}, got_cyc[i], exp_cyc[i]);
      end
      got_words.delete();
      got_cyc.delete();
      exp_words.delete();
      exp_cyc.delete();
   endtask

   // Asserts reset between clock edges so the clear is seen before any edge.
   task automatic apply_reset(input string tag);
      i_reset = 1'b0;
      #2;
      model_reset();
      check_outputs(tag);
      tick();
      i_reset = 1'b1;
   endtask

   initial begin
      logic [31:0] w;
      model_reset();
      tick();
      tick();
      check_outputs("por");
      i_reset = 1'b1;
      tick();

      send_byte(8'h55);
      idle(1);
      check_outputs("idle_ignores_bytes");

      start();
      send_byte(8'h20); idle(2);
      send_byte(8'h01); idle(1);
      send_byte(8'h00); idle(3);
      send_byte(8'h05);
      check_outputs("first_word");
      idle(2);
      check_outputs("strobe_one_cycle");

      start();
      send_byte(8'h8C); send_byte(8'h02); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
      idle(1);
      check_outputs("halt_word");

      send_word(32'h1122_3344, 0);
      start();
      idle(2);
      check_outputs("done_terminal");

      apply_reset("reset_before_fill");
      start();
      for (int i = 0; i < WORD_LIMIT; i++) begin
         w = $urandom;
         if (w == HALT) w = 32'h0;
         send_word(w, 1);
         if (i == WORD_LIMIT/2 - 1) check_outputs("fill_half");
      end
      idle(1);
      check_outputs("fill_full");
      send_word(32'h0000_0000, 0);
      start();
      idle(2);
      check_outputs("overflow_rejected");

      apply_reset("reset_before_midword");
      start();
      send_byte(8'h12);
      send_byte(8'h34);
      apply_reset("reset_midword_async");
      start();
      send_word(32'hAABB_CCDD, 0);
      check_outputs("after_midword_reset");

`ifdef LOADER_TIMEOUT_EN
      apply_reset("reset_before_timeout");
      start();
      send_byte(8'h12);
      send_byte(8'h34);
      idle(20);
      check_outputs("timeout_no_strobe");
      send_word(32'h0102_0304, 0);
      check_outputs("after_timeout");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of test, required completion within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Debug-path loader directly upstream of the IF-stage program memory.
- Packs UART receive bytes into 32-bit instruction words.
- Drives the memory's debug write data/strobe pair: o_instruction_debug to i_instruction_debug, o_flag_instruction_debug to i_flag_instruction_debug.
- Reports completion when the halt word arrives, and an error when the memory would overflow.

Parameters:
SIZE_REGISTER_INST, 32, instruction word width
SIZE_BYTE, 8, UART byte width
SIZE_MEMORY, 10, program memory address width (capacity 2**SIZE_MEMORY words)
HALT_INST, 32'hFFFFFFFF, halt opcode that terminates loading
TIMEOUT_CYCLES, 100000, inter-byte timeout (used only with LOADER_TIMEOUT_EN)

Ports:
i_clk  in  1  single clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle request to begin a load session
i_rx_data  in  SIZE_BYTE  received UART byte
i_rx_done  in  1  one-cycle strobe: i_rx_data valid
o_instruction_debug  out  SIZE_REGISTER_INST  assembled instruction word
o_flag_instruction_debug  out  1  one-cycle write strobe to program memory
o_inst_count  out  SIZE_MEMORY+1  words written this session
o_busy  out  1  high in RECV
o_load_done  out  1  sticky, halt word written
o_error  out  1  sticky, memory capacity exceeded

Behaviour:
- Reset (i_reset low, asynchronous):
  - State goes to IDLE; byte index is 0.
  - All outputs are 0; the partial word register is 0.
- States:
  - IDLE: i_start moves to RECV. i_rx_done is ignored.
  - RECV: o_busy=1. Each i_rx_done shifts i_rx_data in, first byte to bits [31:24] (big-endian). The 2-bit byte index increments and wraps 3->0.
  - DONE: o_load_done=1. Terminal until reset; i_start and bytes are ignored.
  - ERROR: o_error=1. Terminal until reset; i_start and bytes are ignored.
- Word completion is i_rx_done with index==3, at edge N:
  - At edge N, o_instruction_debug is registered with the full word.
  - o_flag_instruction_debug is high for exactly the cycle after edge N (latency 1 from the 4th strobe).
  - o_inst_count increments at edge N.
- Transition on word completion:
  - Word==HALT_INST: the halt word is still written; next state is DONE.
  - Else, if the count after increment == 2**SIZE_MEMORY: next state is ERROR. The 1024th word is written; no further words are accepted.
  - Otherwise: stay in RECV.
- Back-to-back strobes on consecutive cycles are accepted. No byte is lost across a word boundary; the next strobe becomes byte 0 of the next word.
- i_start while in RECV is ignored.
- o_instruction_debug holds its last value between strobes.
- Reset mid-word discards the partial bytes.
- o_inst_count saturates at 2**SIZE_MEMORY; the extra bit prevents wrap to 0.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RECV while the byte index != 0.
  - It clears on every i_rx_done.
  - Reaching TIMEOUT_CYCLES discards the partial word: index goes to 0, the partial register goes to 0, no strobe is issued, and the state stays RECV. o_inst_count is unchanged.
- Undefined: no counter; partial words wait indefinitely.
- Ports are identical in both builds.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RECV, DONE, ERROR)
  - HALT_INST value
  - SIZE_REGISTER_INST, SIZE_BYTE, SIZE_MEMORY widths
- One sub-module, instruction_byte_packer:
  - shift register plus 2-bit index
  - inputs: strobe, byte, clear
  - outputs: word and word_valid
- Parent FSM owns the count, strobe register, flags and the optional timeout.

Test Plan:
- Reset, i_start, then bytes 0x20,0x01,0x00,0x05 on separate strobes -> one strobe cycle after the 4th byte; o_instruction_debug=0x20010005; o_inst_count=1; o_busy=1.
- Two words sent as 8 consecutive-cycle strobes (0x8C,0x02,0x00,0x04, 0xFF,0xFF,0xFF,0xFF) -> strobes exactly 4 cycles apart; second word 0xFFFFFFFF written; o_load_done=1; o_busy=0; o_inst_count=2.
- After DONE: send 4 more bytes plus i_start -> no strobe; outputs unchanged.
- Send 1024 non-halt words (e.g. 0x00000000) -> 1024 strobes; o_error=1 after the last; o_inst_count=1024; a 1025th word produces no strobe.
- Bytes 0x12,0x34 then drop i_reset for 1 cycle mid-clock, then i_start, 0xAA,0xBB,0xCC,0xDD -> reset asynchronously clears outputs; next word=0xAABBCCDD; count=1.
- LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16: 0x12,0x34, idle 20 cycles, then 0x01,0x02,0x03,0x04 -> no strobe for the partial word; word 0x01020304; count=1.
